bcd_counter_multi: RTL and testbench

//   Parametrised multi-digit BCD counter: successor to the single-digit 4-bit counter.

---
 rtl/bcd_counter_multi.sv | 96 +++++++++
 tb/tb_bcd_counter_multi.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_multi.sv
// Multi-digit BCD counter with enable, up/down, validated parallel load,
// optional saturation, combinational terminal count and registered wrap/load-error pulses.
module bcd_counter_multi #(
    parameter int DIGITS   = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                up_dn,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] count,
    output logic                tc,
    output logic                wrap,
    output logic                load_err
);
    localparam int W = 4 * DIGITS;

    logic [W-1:0]      count_reg;
    logic [W-1:0]      step_next;
    logic              wrap_reg;
    logic              load_err_reg;
    logic [DIGITS-1:0] is9;
    logic [DIGITS-1:0] is0;
    logic [DIGITS-1:0] digit_ok;
    logic [DIGITS:0]   all9;
    logic [DIGITS:0]   all0;
    logic              at_limit;
    logic              load_ok;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] d;
            logic [3:0] d_inc;
            logic [3:0] d_dec;
            assign d     = count_reg[4*gi +: 4];
            assign is9[gi] = (d == 4'd9);
            assign is0[gi] = (d == 4'd0);
            assign d_inc = is9[gi] ? 4'd0 : d + 4'd1;
            assign d_dec = is0[gi] ? 4'd9 : d - 4'd1;
            // A digit moves only when every lower digit is at its rollover value.
            assign step_next[4*gi +: 4] = up_dn ? (all9[gi] ? d_inc : d)
                                                : (all0[gi] ? d_dec : d);
            assign digit_ok[gi] = (load_val[4*gi +: 4] <= 4'd9);
        end
    endgenerate

    // Prefix-AND of the per-digit limit flags; all9[k] means digits 0..k-1 are all 9.
    always_comb begin
        all9[0] = 1'b1;
        all0[0] = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            all9[k+1] = all9[k] & is9[k];
            all0[k+1] = all0[k] & is0[k];
        end
    end

    assign at_limit = up_dn ? all9[DIGITS] : all0[DIGITS];
    assign load_ok  = &digit_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg    <= '0;
            wrap_reg     <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            wrap_reg     <= 1'b0;
            load_err_reg <= 1'b0;
            if (load) begin
                if (load_ok) begin
                    count_reg <= load_val;
                end else begin
                    load_err_reg <= 1'b1;
                end
            end else if (en) begin
                if (at_limit) begin
                    // The step chain already yields all-0s/all-9s on rollover.
                    if (!SATURATE) begin
                        count_reg <= step_next;
                        wrap_reg  <= 1'b1;
                    end
                end else begin
                    count_reg <= step_next;
                end
            end
        end
    end

    assign count    = count_reg;
    assign wrap     = wrap_reg;
    assign load_err = load_err_reg;
    assign tc       = en & at_limit;

endmodule

// File: tb/tb_bcd_counter_multi.sv
// Bench for bcd_counter_multi: wrapping and saturating instances share stimulus and
// are checked each cycle against an integer-arithmetic reference model.
module tb_bcd_counter_multi;
    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int MODV   = 10000;

    logic         clk = 1'b0;
    logic         rst, en, up_dn, load;
    logic [W-1:0] load_val;
    logic [W-1:0] count0, count1;
    logic         tc0, tc1, wrap0, wrap1, le0, le1;

    int total = 0;
    int bad   = 0;

    int m0, m1;
    logic ew0, ew1, ele;

    always #5 clk = ~clk;

    bcd_counter_multi #(.DIGITS(DIGITS), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .count(count0), .tc(tc0), .wrap(wrap0), .load_err(le0)
    );

    bcd_counter_multi #(.DIGITS(DIGITS), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .count(count1), .tc(tc1), .wrap(wrap1), .load_err(le1)
    );

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd(input logic [W-1:0] b);
        int r;
        r = 0;
        for (int k = DIGITS - 1; k >= 0; k--) r = r * 10 + int'(b[4*k +: 4]);
        return r;
    endfunction

    function automatic bit bcd_valid(input logic [W-1:0] b);
        bit ok;
        ok = 1'b1;
        for (int k = 0; k < DIGITS; k++) if (b[4*k +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int next_val(input int m, input bit sat, output logic w);
        w = 1'b0;
        if (up_dn) begin
            if (m == MODV - 1) begin
                if (sat) return m;
                w = 1'b1;
                return 0;
            end
            return m + 1;
        end else begin
            if (m == 0) begin
                if (sat) return m;
                w = 1'b1;
                return MODV - 1;
            end
            return m - 1;
        end
    endfunction

    // One clock transaction: drive, check tc before the edge, update model, check after.
    task automatic cycle(input logic r, input logic e, input logic u, input logic l,
                         input logic [W-1:0] v);
        logic exp_tc0, exp_tc1, w;
        int n;
        rst = r; en = e; up_dn = u; load = l; load_val = v;
        #2;
        exp_tc0 = e & (u ? (m0 == MODV - 1) : (m0 == 0));
        exp_tc1 = e & (u ? (m1 == MODV - 1) : (m1 == 0));
        chk("tc_wrap", W'(tc0), W'(exp_tc0));
        chk("tc_sat",  W'(tc1), W'(exp_tc1));
        @(posedge clk);
        ew0 = 1'b0; ew1 = 1'b0; ele = 1'b0;
        if (r) begin
            m0 = 0; m1 = 0;
        end else if (l) begin
            if (bcd_valid(v)) begin
                m0 = from_bcd(v); m1 = from_bcd(v);
            end else begin
                ele = 1'b1;
            end
        end else if (e) begin
            n = next_val(m0, 1'b0, w); m0 = n; ew0 = w;
            n = next_val(m1, 1'b1, w); m1 = n; ew1 = w;
        end
        #1;
        chk("count_wrap", count0, to_bcd(m0));
        chk("count_sat",  count1, to_bcd(m1));
        chk("wrap_wrap",  W'(wrap0), W'(ew0));
        chk("wrap_sat",   W'(wrap1), W'(ew1));
        chk("lerr_wrap",  W'(le0), W'(ele));
        chk("lerr_sat",   W'(le1), W'(ele));
        chk("excl", W'(wrap0 & le0), W'(0));
        $display("txn rst=%0b en=%0b up=%0b load=%0b val=%h -> c0=%h c1=%h w=%0b/%0b le=%0b",
                 r, e, u, l, v, count0, count1, wrap0, wrap1, le0);
    endtask

    initial begin
        logic [W-1:0] rv;
        m0 = 0; m1 = 0;
        rst = 1'b1; en = 1'b1; up_dn = 1'b1; load = 1'b1; load_val = 16'h1234;
        @(posedge clk); #1;

        // Reset held with en and load active.
        cycle(1, 1, 1, 1, 16'h5678);
        cycle(1, 1, 1, 1, 16'h5678);
        chk("reset_count", count0, 16'h0000);

        // Decimal carry across digits.
        cycle(0, 0, 1, 1, 16'h0099);
        cycle(0, 1, 1, 0, 16'h0000);
        chk("carry_0100", count0, 16'h0100);
        cycle(0, 1, 1, 0, 16'h0000);
        chk("carry_0101", count0, 16'h0101);

        // Upper terminal count and rollover.
        cycle(0, 0, 1, 1, 16'h9998);
        cycle(0, 1, 1, 0, 16'h0000);
        cycle(0, 1, 1, 0, 16'h0000);
        chk("rollover_up", count0, 16'h0000);
        cycle(0, 0, 1, 0, 16'h0000);

        // Lower limit underflow.
        cycle(0, 0, 0, 1, 16'h0000);
        cycle(0, 1, 0, 0, 16'h0000);
        chk("underflow_wrap", count0, 16'h9999);
        chk("underflow_sat",  count1, 16'h0000);

        // Rejected load, then valid load.
        cycle(0, 1, 1, 1, 16'h12A4);
        cycle(0, 0, 1, 1, 16'h1234);
        chk("load_ok", count0, 16'h1234);

        // Direction toggling, then hold.
        cycle(0, 0, 1, 1, 16'h0500);
        cycle(0, 1, 1, 0, 16'h0000);
        cycle(0, 1, 0, 0, 16'h0000);
        cycle(0, 1, 1, 0, 16'h0000);
        chk("toggle_0501", count0, 16'h0501);
        cycle(0, 0, 0, 0, 16'h0000);
        cycle(0, 0, 1, 0, 16'h0000);

        // Random traffic, biased toward limits via loads near 0000/9999.
        for (int i = 0; i < 400; i++) begin
            rv = W'($urandom);
            case ($urandom_range(0, 3))
                0: rv = 16'h9997 + W'($urandom_range(0, 2));
                1: rv = W'($urandom_range(0, 2));
                default: ;
            endcase
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom), ($urandom_range(0, 9) == 0), rv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
